// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // Returned in place of an instruction for misaligned or out-of-range fetches (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } imem_state_t;

endpackage : imem_pkg

// File: rtl/imem_responder_if.sv
// Fetch request/response channel between a fetch unit (master) and the instruction memory (slave).
interface imem_responder_if #(
    parameter int unsigned XLEN = 32
);

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_err
    );

endinterface : imem_responder_if

// File: rtl/imem_array.sv
// Word storage: one synchronous write port, one combinational read port, contents not reset.
module imem_array #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_idx_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic [AW-1:0]   rd_idx_i,
    output logic [XLEN-1:0] rd_data_o
);

    logic [XLEN-1:0] mem_q [DEPTH];

    // Preload write; a read of the same word in the same cycle still sees the old contents.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule : imem_array

// File: rtl/imem_responder.sv
// Latency-bearing instruction memory answering one fetch at a time over a valid/ready channel.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned xlen    = XLEN_DEFAULT,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    imem_responder_if.slave bus,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [xlen-1:0] wr_addr,
    input  logic [xlen-1:0] wr_data
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CNT_W    = 3;
    // Latency 1 skips BUSY entirely, so the load value is only meaningful for LATENCY >= 2.
    localparam int unsigned CNT_LOAD = (LATENCY > 1) ? (LATENCY - 2) : 0;

    imem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [xlen-1:0]  resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;

    logic             req_ready_c;
    logic             accept_c;
    logic             req_bad_c;
    logic             wr_ok_c;
    logic [xlen-1:0]  rd_data_c;

    // Addresses must be word aligned and fall inside the 4*DEPTH byte window.
    assign req_bad_c = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[xlen-1:AW+2] != '0);
    assign wr_ok_c   = wr_en && (wr_addr[1:0] == 2'b00) && (wr_addr[xlen-1:AW+2] == '0);

    imem_array #(
        .XLEN  (xlen),
        .DEPTH (DEPTH)
    ) u_array (
        .clk       (clk),
        .wr_en_i   (wr_ok_c),
        .wr_idx_i  (wr_addr[AW+1:2]),
        .wr_data_i (wr_data),
        .rd_idx_i  (bus.req_addr[AW+1:2]),
        .rd_data_o (rd_data_c)
    );

    // Request acceptance: open in IDLE, follows the consumer in RESP, always closed while flushing.
    always_comb begin
        req_ready_c = 1'b0;
        case (state_q)
            IDLE:    req_ready_c = 1'b1;
            RESP:    req_ready_c = bus.resp_ready;
            default: req_ready_c = 1'b0;
        endcase
        if (flush) begin
            req_ready_c = 1'b0;
        end
    end

    assign accept_c = bus.req_valid && req_ready_c;

    // Next-state logic; an accepted request snapshots its response word immediately.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;

        case (state_q)
            IDLE, RESP: begin
                if (accept_c) begin
                    resp_err_d  = req_bad_c;
                    resp_data_d = req_bad_c ? xlen'(NOP_INSTR) : rd_data_c;
                    cnt_d       = CNT_W'(CNT_LOAD);
                    state_d     = (LATENCY == 1) ? RESP : BUSY;
                end else if ((state_q == RESP) && bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    // State, counter and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

endmodule : imem_responder

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: LATENCY=2 instance for most cases, LATENCY=1 for streaming.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    int n_vec;
    int n_err;

    imem_responder_if #(.XLEN(32)) bus2 ();
    imem_responder_if #(.XLEN(32)) bus1 ();

    imem_responder #(.xlen(32), .DEPTH(1024), .LATENCY(2)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus2),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    imem_responder #(.xlen(32), .DEPTH(1024), .LATENCY(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus1),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Wait (bounded) for a LATENCY=2 response, check it, then consume it.
    task automatic wait_resp(input string tag, input logic [31:0] exp_d, input logic exp_e);
        for (int k = 0; k < 20 && !bus2.resp_valid; k++) tick();
        check({tag, "_valid"}, 32'(bus2.resp_valid), 32'd1);
        check({tag, "_data"}, bus2.resp_data, exp_d);
        check({tag, "_err"}, 32'(bus2.resp_err), 32'(exp_e));
        bus2.resp_ready = 1'b1;
        tick();
    endtask

    // Single read on the LATENCY=2 instance, request issued from IDLE.
    task automatic read2(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
        bus2.req_valid  = 1'b1;
        bus2.req_addr   = a;
        bus2.resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 20 && !bus2.req_ready; k++) tick();
        tick();
        bus2.req_valid = 1'b0;
        wait_resp(tag, exp_d, exp_e);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        flush = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        bus2.req_valid = 1'b0;
        bus2.req_addr = '0;
        bus2.resp_ready = 1'b1;
        bus1.req_valid = 1'b0;
        bus1.req_addr = '0;
        bus1.resp_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        check("rst_req_ready", 32'(bus2.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
        check("rst_resp_data", bus2.resp_data, 32'd0);
        check("rst_resp_err", 32'(bus2.resp_err), 32'd0);
        rst = 1'b0;
        tick();

        // Preload program words, plus writes that must be dropped
        write_word(32'h0000_0000, 32'h0C0C_0C0C);
        write_word(32'h0000_0008, 32'h0050_0093);
        write_word(32'h0000_0010, 32'h2222_2222);
        write_word(32'h0000_0014, 32'h1111_1111);
        write_word(32'h0000_0020, 32'hAAAA_5555);
        write_word(32'h0000_0022, 32'h0BAD_0BAD);
        write_word(32'h0000_1000, 32'h0BAD_1000);
        for (int i = 0; i < 8; i++) write_word(32'h40 + 32'(i) * 4, 32'h1000 + 32'(i));

        // Basic read, cycle-exact
        bus2.req_valid = 1'b1;
        bus2.req_addr = 32'h8;
        #1;
        check("basic_req_ready_c0", 32'(bus2.req_ready), 32'd1);
        tick();
        bus2.req_valid = 1'b0;
        check("basic_valid_c1", 32'(bus2.resp_valid), 32'd0);
        check("basic_busy_ready_c1", 32'(bus2.req_ready), 32'd0);
        tick();
        check("basic_valid_c2", 32'(bus2.resp_valid), 32'd1);
        check("basic_data_c2", bus2.resp_data, 32'h0050_0093);
        check("basic_err_c2", 32'(bus2.resp_err), 32'd0);
        tick();
        check("basic_idle_valid", 32'(bus2.resp_valid), 32'd0);
        check("basic_idle_ready", 32'(bus2.req_ready), 32'd1);

        // Misaligned, out of range, and dropped writes
        read2("misaligned", 32'h6, 32'h0000_0013, 1'b1);
        read2("out_of_range", 32'h1000, 32'h0000_0013, 1'b1);
        read2("word0_no_alias", 32'h0, 32'h0C0C_0C0C, 1'b0);

        // Backpressure then back-to-back accept
        bus2.req_valid = 1'b1;
        bus2.req_addr = 32'h14;
        bus2.resp_ready = 1'b0;
        tick();
        bus2.req_addr = 32'h8;
        for (int k = 0; k < 20 && !bus2.resp_valid; k++) tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(bus2.resp_valid), 32'd1);
            check("bp_data", bus2.resp_data, 32'h1111_1111);
            check("bp_req_ready", 32'(bus2.req_ready), 32'd0);
            tick();
        end
        bus2.resp_ready = 1'b1;
        #1;
        check("b2b_req_ready", 32'(bus2.req_ready), 32'd1);
        tick();
        bus2.req_valid = 1'b0;
        check("b2b_busy_valid", 32'(bus2.resp_valid), 32'd0);
        tick();
        check("b2b_valid", 32'(bus2.resp_valid), 32'd1);
        check("b2b_data", bus2.resp_data, 32'h0050_0093);
        tick();

        // Flush while BUSY; the following request must be held off during the flush cycle
        bus2.req_valid = 1'b1;
        bus2.req_addr = 32'h10;
        tick();
        bus2.req_addr = 32'h14;
        flush = 1'b1;
        #1;
        check("flush_req_ready", 32'(bus2.req_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_after_valid", 32'(bus2.resp_valid), 32'd0);
        check("flush_after_ready", 32'(bus2.req_ready), 32'd1);
        tick();
        bus2.req_valid = 1'b0;
        check("flush_next_busy", 32'(bus2.resp_valid), 32'd0);
        tick();
        check("flush_next_valid", 32'(bus2.resp_valid), 32'd1);
        check("flush_next_data", bus2.resp_data, 32'h1111_1111);
        tick();

        // Write/read collision returns old word
        bus2.req_valid = 1'b1;
        bus2.req_addr = 32'h20;
        wr_en = 1'b1;
        wr_addr = 32'h20;
        wr_data = 32'hDEAD_BEEF;
        tick();
        bus2.req_valid = 1'b0;
        wr_en = 1'b0;
        wait_resp("collide_old", 32'hAAAA_5555, 1'b0);
        read2("collide_new", 32'h20, 32'hDEAD_BEEF, 1'b0);

        // Asynchronous reset while a response is pending
        bus2.req_valid = 1'b1;
        bus2.req_addr = 32'h8;
        bus2.resp_ready = 1'b0;
        tick();
        bus2.req_valid = 1'b0;
        for (int k = 0; k < 20 && !bus2.resp_valid; k++) tick();
        check("pre_rst_valid", 32'(bus2.resp_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus2.resp_valid), 32'd0);
        check("async_rst_data", bus2.resp_data, 32'd0);
        check("async_rst_ready", 32'(bus2.req_ready), 32'd1);
        tick();
        rst = 1'b0;
        bus2.resp_ready = 1'b1;
        tick();

        // LATENCY=1 streaming: one response per cycle, in order
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                bus1.req_valid = 1'b1;
                bus1.req_addr = 32'h40 + 32'(i) * 4;
            end else begin
                bus1.req_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                check("stream_valid", 32'(bus1.resp_valid), 32'd1);
                check("stream_data", bus1.resp_data, 32'h1000 + 32'(i - 1));
            end
            if (i < 8) check("stream_ready", 32'(bus1.req_ready), 32'd1);
            tick();
        end
        check("stream_end_valid", 32'(bus1.resp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_imem_responder

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the fetch unit's address requests: it accepts one word-aligned fetch address at a time, waits a configurable number of cycles, then presents the instruction word on a valid/ready response channel. It sits on the memory side of the fetch interface, so the fetch unit can be exercised against a realistic, latency-bearing memory. A side-band write port preloads programs. A flush input discards any outstanding fetch when the PC is redirected.

## Interface
- `xlen`, 32: data and address width.
- `DEPTH`, 1024: number of `xlen`-bit words stored; power of two.
- `LATENCY`, 2: cycles from request acceptance to `resp_valid`; legal range 1..8.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_addr`  in  `xlen`  byte address of the instruction.
- `resp_valid`  out  1  response word valid.
- `resp_ready`  in  1  fetch unit consumes the response.
- `resp_data`  out  `xlen`  instruction word.
- `resp_err`  out  1  address misaligned or out of range.
- `flush`  in  1  drop any outstanding request or response.
- `wr_en`  in  1  preload write strobe.
- `wr_addr`  in  `xlen`  preload byte address (word-aligned).
- `wr_data`  in  `xlen`  preload word.

## Operation
- Three-state FSM: IDLE, BUSY, RESP. Reset state is IDLE.
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_err`=0. The latency counter is 0. Memory contents are not reset.
- IDLE: `req_ready`=1. A handshake (`req_valid` && `req_ready`) captures the response:
  - Word index is `req_addr[log2(DEPTH)+1:2]`.
  - If `req_addr[1:0]`≠0 or `req_addr` ≥ 4·DEPTH, `resp_err` is set and `resp_data` is 0x0000_0013 (NOP).
  - Otherwise `resp_data` is the stored word.
  - Next state: RESP if LATENCY=1; else BUSY with the counter loaded to LATENCY−2.
- BUSY: `req_ready`=0. The counter decrements each cycle. At 0, next state is RESP.
- RESP: `resp_valid`=1. `resp_data` and `resp_err` are held stable until the handshake.
  - `req_ready` = `resp_ready`, so a new request is accepted in the same cycle the response completes (back-to-back).
  - Response handshake without a new request: go to IDLE.
  - Response handshake with a new request: the new request is processed as in IDLE.
- Flush has priority in every state:
  - Next state is IDLE and `resp_valid`=0 next cycle.
  - `req_ready` is forced to 0 in the flush cycle, so no request is accepted then.
  - A response handshaking in the flush cycle still completes; the consumer owns discarding it.
- Read data is sampled at request acceptance. A write to the same word in the acceptance cycle returns the old word. Writes in later cycles do not alter the pending response.
- Writes:
  - Occur in any state, including during flush.
  - Misaligned or out-of-range writes are ignored.
  - `wr_addr[1:0]` is ignored for alignment purposes only when it is 0.

## Timing
- Request accepted at edge T gives `resp_valid` high after edge T+LATENCY−1, i.e. visible in cycle T+LATENCY.
- Sustained throughput with `resp_ready`=1 is one word per LATENCY cycles.
- `resp_valid` never drops without a handshake, except on flush or reset.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous) and the pending request is lost.

## Structure
- Package `imem_pkg`:
  - state enum `imem_state_t` {IDLE, BUSY, RESP};
  - constant `NOP_INSTR` = 32'h0000_0013;
  - default `xlen`.
- Sub-module `imem_array`: DEPTH×xlen storage with one synchronous write port and one combinational read port.
- FSM, counter and response registers live in `imem_responder`.

## Test plan
- **Reset, then basic read, LATENCY=2.** Preload word 0x00500093 at 0x8. Request 0x8 at cycle 0 with `resp_ready`=1.
  -> `resp_valid` in cycle 2, `resp_data`=0x00500093, `resp_err`=0, FSM back in IDLE.
- **Misaligned and out-of-range.** Request 0x6, then 0x1000 (DEPTH=1024).
  -> each returns `resp_err`=1, `resp_data`=0x00000013.
- **Backpressure.** Hold `resp_ready`=0 for 5 cycles after `resp_valid`.
  -> `resp_data` is stable and `req_ready`=0 throughout. Release with a new request pending -> back-to-back accept in the same cycle.
- **Flush in BUSY.** Request 0x10, flush one cycle later.
  -> no `resp_valid` for that request; `req_ready`=1 the cycle after flush; the next request 0x14 returns the correct word.
- **Write/read collision.** Write 0xDEADBEEF to 0x20 in the same cycle a request to 0x20 is accepted.
  -> response carries the old word; a second read returns 0xDEADBEEF.
- **LATENCY=1 streaming.** Issue 8 consecutive requests with `resp_ready`=1.
  -> one response every cycle after the first, addresses in order.
